// File: rtl/pll_clken_pkg.sv
// Shared types and width helpers for the NCO-based clock-enable generator.
package pll_clken_pkg;

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    UPDATE  = 2'd1,
    LOCKING = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int lock_cnt_width(input int lock_cycles);
    return $clog2(lock_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_clken_gen_if.sv
// Valid/ready configuration channel: selects a channel and supplies its increment and start phase.
interface pll_clken_gen_if
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32
) ();
  localparam int CH_W = ch_width(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic [ACC_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, cfg_phase, output cfg_ready);
endinterface

// File: rtl/pll_clken_gen_nco_ch.sv
// One NCO channel: phase accumulator whose carry becomes a clock-enable pulse and whose MSB
// becomes a ~50% square wave.
module pll_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             load,
  input  logic [ACC_W-1:0] inc,
  input  logic [ACC_W-1:0] phase,
  output logic             clk_en,
  output logic             clk_sq
);
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum_s;
  logic             clk_en_q, clk_en_d;
  logic             clk_sq_q, clk_sq_d;

  // Next-state: a write (re)programs the channel, a load realigns it, otherwise accumulate.
  always_comb begin
    sum_s    = {1'b0, acc_q} + {1'b0, inc_q};
    inc_d    = inc_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    clk_en_d = 1'b0;
    if (wr) begin
      inc_d   = inc;
      phase_d = phase;
      acc_d   = phase;
    end else if (load) begin
      acc_d   = phase_q;
    end else begin
      acc_d    = sum_s[ACC_W-1:0];
      clk_en_d = sum_s[ACC_W];
    end
    clk_sq_d = acc_d[ACC_W-1];
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q    <= '0;
      phase_q  <= '0;
      acc_q    <= '0;
      clk_en_q <= 1'b0;
      clk_sq_q <= 1'b0;
    end else begin
      inc_q    <= inc_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      clk_en_q <= clk_en_d;
      clk_sq_q <= clk_sq_d;
    end
  end

  assign clk_en = clk_en_q;
  assign clk_sq = clk_sq_q;
endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel clock-enable generator: config decode, lock FSM with settle counter, and one
// NCO per channel.
module pll_clken_gen
  import pll_clken_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic              refclk,
  input  logic              rst_n,
  pll_clken_gen_if.slave    cfg,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_sq,
  output logic              cfg_err,
  output logic              locked
);
  localparam int CH_W = ch_width(NUM_CH);
  localparam int LCW  = lock_cnt_width(LOCK_CYCLES);
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0]  CNT_ONE   = LCW'(1);
  localparam logic [CH_W:0]   CH_LIMIT  = (CH_W + 1)'(NUM_CH);

  state_e            state_q, state_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              ready_q, ready_d;
  logic              locked_q, locked_d;
  logic              cfg_err_q, cfg_err_d;
  logic              xfer_s, ch_ok_s, good_wr_s;
  logic [NUM_CH-1:0] wr_s;

  // Transfer decode; an out-of-range channel is still accepted but only flags an error.
  always_comb begin
    xfer_s    = cfg.cfg_valid && ready_q;
    ch_ok_s   = ({1'b0, cfg.cfg_ch} < CH_LIMIT);
    good_wr_s = xfer_s && ch_ok_s;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_s[i] = good_wr_s && ({1'b0, cfg.cfg_ch} == (CH_W + 1)'(i));
    end
  end

  // Lock FSM: any accepted write restarts the settle window; realign restarts counting only.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cfg_err_d  = xfer_s && !ch_ok_s;
    if (good_wr_s) begin
      state_d    = UPDATE;
      lock_cnt_d = '0;
    end else if (sync_all && ((state_q == LOCKING) || (state_q == LOCKED))) begin
      state_d    = LOCKING;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        UNCFG:   state_d = UNCFG;
        UPDATE: begin
          state_d    = LOCKING;
          lock_cnt_d = '0;
        end
        LOCKING: begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d = LOCKED;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_ONE;
          end
        end
        LOCKED:  state_d = LOCKED;
        default: state_d = UNCFG;
      endcase
    end
    ready_d  = (state_d != UPDATE);
    locked_d = (state_d == LOCKED);
  end

  // FSM state, settle counter and registered handshake/status outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNCFG;
      lock_cnt_q <= '0;
      ready_q    <= 1'b1;
      locked_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      ready_q    <= ready_d;
      locked_q   <= locked_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign locked        = locked_q;
  assign cfg_err       = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_nco_ch #(.ACC_W(ACC_W)) u_nco (
      .clk    (refclk),
      .rst_n  (rst_n),
      .wr     (wr_s[g]),
      .load   (sync_all),
      .inc    (cfg.cfg_inc),
      .phase  (cfg.cfg_phase),
      .clk_en (clk_en[g]),
      .clk_sq (clk_sq[g])
    );
  end
endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed bench for pll_clken_gen with NUM_CH=3, ACC_W=8, LOCK_CYCLES=8.
module tb_pll_clken_gen;
  localparam int NUM_CH = 3;
  localparam int ACC_W  = 8;
  localparam int LOCK_CYCLES = 8;

  logic              refclk;
  logic              rst_n;
  logic              sync_all;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_sq;
  logic              cfg_err;
  logic              locked;
  int                n_cmp;
  int                n_err;

  pll_clken_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  pll_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg      (cfg_if.slave),
    .sync_all (sync_all),
    .clk_en   (clk_en),
    .clk_sq   (clk_sq),
    .cfg_err  (cfg_err),
    .locked   (locked)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Drives one config beat; returns 1ns after the accepting edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] ph);
    chk("ready_before_write", {31'd0, cfg_if.cfg_ready}, 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_inc   = inc;
    cfg_if.cfg_phase = ph;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sync_all = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_inc   = 8'd0;
    cfg_if.cfg_phase = 8'd0;

    // Reset values
    #12;
    chk("rst_clk_en", {29'd0, clk_en}, 32'd0);
    chk("rst_clk_sq", {29'd0, clk_sq}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_no_ticks", {29'd0, clk_en}, 32'd0);
      chk("idle_unlocked", {31'd0, locked}, 32'd0);
    end

    // ch0 inc=64: tick every 4 cycles, square 2 high / 2 low, lock at accept+9
    cfg_write(2'd0, 8'd64, 8'd0);
    chk("upd_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("upd_clk_en0", {31'd0, clk_en[0]}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("inc64_en0", {31'd0, clk_en[0]}, {31'd0, (k % 4) == 0});
      chk("inc64_sq0", {31'd0, clk_sq[0]}, {31'd0, (k % 4) >= 2});
      chk("inc64_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
      chk("inc64_locked", {31'd0, locked}, {31'd0, k >= 9});
    end

    // ch0 inc=96: ticks at accept+3,6,8,11,14,16 (3 per 8 cycles)
    cfg_write(2'd0, 8'd96, 8'd0);
    chk("rewrite_lock_fall", {31'd0, locked}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("inc96_en0", {31'd0, clk_en[0]}, {31'd0, ((96 * k) / 256) != ((96 * (k - 1)) / 256)});
      chk("inc96_sq0", {31'd0, clk_sq[0]}, {31'd0, ((96 * k) % 256) >= 128});
      chk("inc96_en1_idle", {31'd0, clk_en[1]}, 32'd0);
      chk("inc96_locked", {31'd0, locked}, {31'd0, k >= 9});
    end

    // Rewrite ch1 while locked
    chk("pre_ch1_locked", {31'd0, locked}, 32'd1);
    cfg_write(2'd1, 8'd64, 8'd0);
    chk("ch1_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("ch1_locked_low", {31'd0, locked}, 32'd0);
    step();
    chk("ch1_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("ch1_still_unlocked", {31'd0, locked}, 32'd0);
    repeat (7) step();
    chk("ch1_relock_early", {31'd0, locked}, 32'd0);
    step();
    chk("ch1_relock", {31'd0, locked}, 32'd1);

    // Antiphase channels realigned by sync_all; the suppressed wrap lands on the sync edge
    cfg_write(2'd0, 8'd64, 8'd0);
    step();
    cfg_write(2'd1, 8'd64, 8'd128);
    step();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    chk("sync_no_en", {29'd0, clk_en}, 32'd0);
    chk("sync_sq0", {31'd0, clk_sq[0]}, 32'd0);
    chk("sync_sq1", {31'd0, clk_sq[1]}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("anti_sq0", {31'd0, clk_sq[0]}, {31'd0, (k % 4) >= 2});
      chk("anti_sq1", {31'd0, clk_sq[1]}, {31'd0, (k % 4) < 2});
      chk("anti_en0", {31'd0, clk_en[0]}, {31'd0, (k % 4) == 0});
      chk("anti_en1", {31'd0, clk_en[1]}, {31'd0, (k % 4) == 2});
      chk("sync_relock", {31'd0, locked}, {31'd0, k >= 8});
    end

    // Out-of-range channel: error pulse, nothing else changes
    cfg_write(2'd3, 8'd1, 8'd200);
    chk("badch_err", {31'd0, cfg_err}, 32'd1);
    chk("badch_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    chk("badch_locked", {31'd0, locked}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("badch_err_clear", {31'd0, cfg_err}, 32'd0);
      chk("badch_locked_hold", {31'd0, locked}, 32'd1);
      chk("badch_sq2", {31'd0, clk_sq[2]}, 32'd0);
      chk("badch_en2", {31'd0, clk_en[2]}, 32'd0);
    end

    // Asynchronous reset between edges while running locked
    chk("pre_rst_sq_active", {31'd0, |clk_sq}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk_en", {29'd0, clk_en}, 32'd0);
    chk("arst_clk_sq", {29'd0, clk_sq}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_no_ticks", {29'd0, clk_en}, 32'd0);
      chk("post_rst_no_sq", {29'd0, clk_sq}, 32'd0);
      chk("post_rst_unlocked", {31'd0, locked}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
